// File: rtl/lcd_timing_pkg.sv
// ---------------------------------------------------------------------------
// lcd_timing_pkg
// Shared definitions for the 800x480 parallel RGB LCD timing generator:
//   - default panel timing (clocks per line segment, lines per frame segment)
//   - rgb565_t pixel type and the run/idle state enum
//   - counter width helpers (x_width / y_width)
//   - colour-bar constants and the bar lookup used by the test pattern
// No ports; imported with import lcd_timing_pkg::*.
// ---------------------------------------------------------------------------
package lcd_timing_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FRONT_DEF  = 210;
  localparam int H_SYNC_DEF   = 20;
  localparam int H_BACK_DEF   = 26;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 22;
  localparam int V_SYNC_DEF   = 10;
  localparam int V_BACK_DEF   = 13;

  typedef logic [15:0] rgb565_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } lcd_state_e;

  // Counter widths are just enough bits to hold 0..TOTAL-1.
  function automatic int x_width(input int h_total);
    return $clog2(h_total);
  endfunction

  function automatic int y_width(input int v_total);
    return $clog2(v_total);
  endfunction

  localparam int BAR_WIDTH = 100;

  localparam rgb565_t BAR_WHITE   = 16'hFFFF;
  localparam rgb565_t BAR_YELLOW  = 16'hFFE0;
  localparam rgb565_t BAR_CYAN    = 16'h07FF;
  localparam rgb565_t BAR_GREEN   = 16'h07E0;
  localparam rgb565_t BAR_MAGENTA = 16'hF81F;
  localparam rgb565_t BAR_RED     = 16'hF800;
  localparam rgb565_t BAR_BLUE    = 16'h001F;
  localparam rgb565_t BAR_BLACK   = 16'h0000;

  // Bar lookup by column. A compare ladder avoids a divide-by-100 in
  // hardware; anything past the seventh bar boundary is black.
  function automatic rgb565_t colour_bar(input int col);
    rgb565_t c;
    if      (col < 1 * BAR_WIDTH) c = BAR_WHITE;
    else if (col < 2 * BAR_WIDTH) c = BAR_YELLOW;
    else if (col < 3 * BAR_WIDTH) c = BAR_CYAN;
    else if (col < 4 * BAR_WIDTH) c = BAR_GREEN;
    else if (col < 5 * BAR_WIDTH) c = BAR_MAGENTA;
    else if (col < 6 * BAR_WIDTH) c = BAR_RED;
    else if (col < 7 * BAR_WIDTH) c = BAR_BLUE;
    else                          c = BAR_BLACK;
    return c;
  endfunction

endpackage

// File: rtl/lcd_wrap_counter.sv
// ---------------------------------------------------------------------------
// lcd_wrap_counter
// Modulo counter 0..MAX used for both the horizontal (pixel) and vertical
// (line) position of the LCD timing generator.
// Ports:
//   clk   in  1  pixel clock
//   rst_n in  1  asynchronous reset, active-low (count clears to 0)
//   clr   in  1  synchronous clear to 0 (wins over inc)
//   inc   in  1  advance by one this clock
//   cnt   out W  current count
//   wrap  out 1  inc is high while cnt==MAX, i.e. the count returns to 0 on
//                this edge; chains into the next counter's inc
// ---------------------------------------------------------------------------
module lcd_wrap_counter #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap = inc && (cnt_q == W'(MAX));
  assign cnt  = cnt_q;

  // Next count: clear has priority, then wrap back to zero at MAX,
  // otherwise step by one when asked.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_800x480_timing_gen.sv
// ---------------------------------------------------------------------------
// lcd_800x480_timing_gen
// Video timing generator for the 800x480 parallel RGB LCD, pixel clock
// domain. Walks horizontal/vertical counters, exports the current pixel
// coordinate to the upstream pixel generator (stage 0, combinational) and
// drives registered DE/HSYNC/VSYNC/RGB565 to the panel (stage 1, one clock
// after the coordinate).
// Ports:
//   clk         in   1   pixel clock
//   rst_n       in   1   asynchronous reset, active-low
//   en          in   1   run enable (gate on PLL lock upstream)
//   x           out  XW  current column (0 while idle)
//   y           out  YW  current row (0 while idle)
//   visible     out  1   x/y inside the active area
//   frame_start out  1   counters at (0,0) while running and enabled
//   rgb_in      in   16  RGB565 for the current x/y from upstream
//   lcd_de      out  1   data enable
//   lcd_hs      out  1   hsync, asserted level HS_POL
//   lcd_vs      out  1   vsync, asserted level VS_POL
//   lcd_rgb     out  16  RGB565 to the panel (0 outside the active area)
// Build option:
//   LCD_TIMING_TEST_PATTERN_EN  when defined, lcd_rgb shows eight 100-px
//   vertical colour bars instead of rgb_in; timing is unchanged.
// ---------------------------------------------------------------------------
module lcd_800x480_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FRONT  = H_FRONT_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BACK   = H_BACK_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FRONT  = V_FRONT_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BACK   = V_BACK_DEF,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  localparam int  H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int  V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int  XW       = x_width(H_TOTAL),
  localparam int  YW       = y_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          visible,
  output logic          frame_start,
  input  logic [15:0]   rgb_in,
  output logic          lcd_de,
  output logic          lcd_hs,
  output logic          lcd_vs,
  output logic [15:0]   lcd_rgb
);

  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FRONT);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FRONT);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FRONT + V_SYNC);

  lcd_state_e    state_q, state_d;
  logic          run;
  logic          step;
  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;
  logic          hs_active;
  logic          vs_active;
  rgb565_t       pixel;

  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  rgb565_t       rgb_q, rgb_d;

  // The counters only advance when already running and still enabled, so
  // the IDLE->RUN edge leaves them at (0,0) and the first pixel is shown
  // for a full clock. Any clock where that is not true clears them.
  assign run  = (state_q == ST_RUN);
  assign step = run && en;

  // Run/idle control: enable starts a frame, dropping enable stops it
  // wherever the counters happen to be.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en)  state_d = ST_RUN;
      ST_RUN:  if (!en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  lcd_wrap_counter #(
    .MAX (H_TOTAL - 1),
    .W   (XW)
  ) u_h_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!step),
    .inc   (step),
    .cnt   (h_cnt),
    .wrap  (h_wrap)
  );

  lcd_wrap_counter #(
    .MAX (V_TOTAL - 1),
    .W   (YW)
  ) u_v_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!step),
    .inc   (h_wrap),
    .cnt   (v_cnt),
    .wrap  (v_wrap)
  );

  // Stage 0: coordinates and flags straight from the counters. Gating on
  // run keeps everything quiet while idle even though the counters are
  // already zero there.
  assign x           = run ? h_cnt : '0;
  assign y           = run ? v_cnt : '0;
  assign visible     = run && (h_cnt < XW'(H_ACTIVE)) && (v_cnt < YW'(V_ACTIVE));
  assign frame_start = step && (h_cnt == '0) && (v_cnt == '0);
  assign hs_active   = run && (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_active   = run && (v_cnt >= VS_START) && (v_cnt < VS_END);

`ifdef LCD_TIMING_TEST_PATTERN_EN
  assign pixel = colour_bar(int'(h_cnt));
`else
  assign pixel = rgb_in;
`endif

  // Stage 1 next values: blank outside the active area and translate sync
  // windows into the panel's polarity.
  always_comb begin
    de_d  = visible;
    rgb_d = visible ? pixel : 16'h0000;
    hs_d  = hs_active ? HS_POL : ~HS_POL;
    vs_d  = vs_active ? VS_POL : ~VS_POL;
  end

  // Stage 1 registers driving the panel pins; reset leaves syncs idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q  <= 1'b0;
      rgb_q <= 16'h0000;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
    end else begin
      de_q  <= de_d;
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign lcd_de  = de_q;
  assign lcd_rgb = rgb_q;
  assign lcd_hs  = hs_q;
  assign lcd_vs  = vs_q;

endmodule

// File: tb/tb_lcd_800x480_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_lcd_800x480_timing_gen
// Drives two copies of the timing generator from one clock/enable/pixel
// source: one at the real 800x480 timing (line-level behaviour) and one with
// a tiny 16x6 raster so whole frames and the frame wrap fit in a short run.
// Each copy is compared every clock against a reference that tracks a single
// linear position inside the frame.
// ---------------------------------------------------------------------------
module tb_lcd_800x480_timing_gen;

  typedef struct {
    int hAct; int hFront; int hSync; int hTot;
    int vAct; int vFront; int vSync; int vTot;
  } timing_t;

  typedef struct {
    bit          run;
    int          pos;
    bit          de;
    logic [15:0] rgb;
    bit          hsOn;
    bit          vsOn;
  } model_t;

  localparam timing_t TA = '{800, 210, 20, 1056, 480, 22, 10, 525};
  localparam timing_t TB = '{16, 4, 3, 25, 6, 2, 2, 11};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] rgbIn = 16'h0000;

  logic [10:0] xA;  logic [9:0] yA;
  logic        visA, fsA, deA, hsA, vsA;
  logic [15:0] rgbA;
  logic [4:0]  xB;  logic [3:0] yB;
  logic        visB, fsB, deB, hsB, vsB;
  logic [15:0] rgbB;

  int checks = 0;
  int errors = 0;
  model_t mA, mB;

  logic [10:0] sXA; logic [9:0] sYA;
  logic        sDeA, sHsA, sVsA, sFsA, sFsB;
  logic [15:0] sRgbA;

  always #5 clk = ~clk;

  lcd_800x480_timing_gen dutA (
    .clk(clk), .rst_n(rst_n), .en(en), .x(xA), .y(yA), .visible(visA),
    .frame_start(fsA), .rgb_in(rgbIn), .lcd_de(deA), .lcd_hs(hsA),
    .lcd_vs(vsA), .lcd_rgb(rgbA)
  );

  lcd_800x480_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .en(en), .x(xB), .y(yB), .visible(visB),
    .frame_start(fsB), .rgb_in(rgbIn), .lcd_de(deB), .lcd_hs(hsB),
    .lcd_vs(vsB), .lcd_rgb(rgbB)
  );

  // Reference: position is a single index into the frame; column and row
  // fall out of it by division.
  function automatic int mX(timing_t t, model_t m);
    return m.run ? (m.pos % t.hTot) : 0;
  endfunction

  function automatic int mY(timing_t t, model_t m);
    return m.run ? (m.pos / t.hTot) : 0;
  endfunction

  function automatic bit mVis(timing_t t, model_t m);
    return m.run && (mX(t, m) < t.hAct) && (mY(t, m) < t.vAct);
  endfunction

  function automatic logic [15:0] expPixel(int col, logic [15:0] pix);
`ifdef LCD_TIMING_TEST_PATTERN_EN
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    return bars[col / 100];
`else
    return (col >= 0) ? pix : pix;
`endif
  endfunction

  function automatic model_t resetModel();
    model_t m;
    m.run = 1'b0; m.pos = 0; m.de = 1'b0; m.rgb = 16'h0000;
    m.hsOn = 1'b0; m.vsOn = 1'b0;
    return m;
  endfunction

  function automatic model_t nextModel(timing_t t, model_t m, bit e, logic [15:0] pix);
    model_t n = m;
    int cx = mX(t, m);
    int cy = mY(t, m);
    bit vis = mVis(t, m);
    n.de   = vis;
    n.rgb  = vis ? expPixel(cx, pix) : 16'h0000;
    n.hsOn = m.run && (cx >= t.hAct + t.hFront) && (cx < t.hAct + t.hFront + t.hSync);
    n.vsOn = m.run && (cy >= t.vAct + t.vFront) && (cy < t.vAct + t.vFront + t.vSync);
    if (!m.run) begin
      n.run = e;
      n.pos = 0;
    end else if (e) begin
      n.pos = (m.pos + 1) % (t.hTot * t.vTot);
    end else begin
      n.run = 1'b0;
      n.pos = 0;
    end
    return n;
  endfunction

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkInst(string tag, timing_t t, model_t m,
                           logic [31:0] ox, logic [31:0] oy, logic [31:0] ov,
                           logic [31:0] ofs, logic [31:0] ode, logic [31:0] orgb,
                           logic [31:0] ohs, logic [31:0] ovs);
    check({tag, ".x"}, ox, mX(t, m));
    check({tag, ".y"}, oy, mY(t, m));
    check({tag, ".visible"}, ov, 32'(mVis(t, m)));
    check({tag, ".frame_start"}, ofs, 32'(m.run && en && m.pos == 0));
    check({tag, ".lcd_de"}, ode, 32'(m.de));
    check({tag, ".lcd_rgb"}, orgb, 32'(m.rgb));
    check({tag, ".lcd_hs"}, ohs, 32'(!m.hsOn));
    check({tag, ".lcd_vs"}, ovs, 32'(!m.vsOn));
  endtask

  task automatic checkOutput();
    checkInst("A", TA, mA, xA, yA, visA, fsA, deA, rgbA, hsA, vsA);
    checkInst("B", TB, mB, xB, yB, visB, fsB, deB, rgbB, hsB, vsB);
  endtask

  task automatic applyStimulus(bit e, logic [15:0] pix);
    en    = e;
    rgbIn = pix;
  endtask

  // One clock: drive, compare mid-cycle, capture samples, advance the
  // reference on the active edge.
  task automatic runCycle(bit e, logic [15:0] pix);
    applyStimulus(e, pix);
    @(negedge clk);
    checkOutput();
    sXA = xA; sYA = yA; sDeA = deA; sHsA = hsA; sVsA = vsA;
    sFsA = fsA; sFsB = fsB; sRgbA = rgbA;
    @(posedge clk);
    mA = nextModel(TA, mA, e, pix);
    mB = nextModel(TB, mB, e, pix);
    #1;
  endtask

  initial begin
    int deCnt = 0, hsLowCnt = 0, firstHs = -1, x1010 = -1, line1 = -1;
    int fsLast = -1, fsPulses = 0;

    $display("[TB] start");
    mA = resetModel();
    mB = resetModel();
    applyStimulus(1'b1, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    rst_n = 1'b1;

    // Free run from reset: line timing on A, several frames on B.
    for (int k = 0; k < 2200; k++) begin
      runCycle(1'b1, 16'($urandom));
      if (k >= 2 && k < 2 + 1056) begin
        deCnt    += int'(sDeA);
        hsLowCnt += int'(!sHsA);
        if (!sHsA && firstHs < 0) firstHs = k;
      end
      if (sXA == 11'd1010 && x1010 < 0) x1010 = k;
      if (sXA == 11'd0 && sYA == 10'd1 && line1 < 0) line1 = k;
      if (sFsB) begin
        if (fsLast >= 0) check("B.framePeriod", k - fsLast, 275);
        fsLast = k;
        fsPulses++;
      end
    end
    check("A.deLine", deCnt, 800);
    check("A.hsLowLen", hsLowCnt, 20);
    check("A.x1010At", x1010, 1011);
    check("A.hsStart", firstHs, 1012);
    check("A.lineLen", line1, 1057);
    check("B.framePulses", fsPulses, 8);

    // Drop enable mid-line on A, then bring it back.
    for (int g = 0; g < 1100 && mX(TA, mA) != 400; g++) runCycle(1'b1, 16'($urandom));
    check("A.dropAtX400", mX(TA, mA), 400);
    runCycle(1'b0, 16'($urandom));
    runCycle(1'b0, 16'($urandom));
    check("A.dropX", sXA, 0);
    check("A.dropY", sYA, 0);
    runCycle(1'b1, 16'($urandom));
    check("A.blankDe", sDeA, 0);
    check("A.blankHs", sHsA, 1);
    check("A.blankVs", sVsA, 1);
    check("A.blankRgb", sRgbA, 0);
    runCycle(1'b1, 16'h1234);
    check("A.restartFs", sFsA, 1);
    check("A.restartX", sXA, 0);
    runCycle(1'b1, 16'h1234);
    check("A.firstRgb", sRgbA, 32'(expPixel(0, 16'h1234)));

    // Random enable drops.
    for (int k = 0; k < 1500; k++) runCycle($urandom_range(0, 15) != 0, 16'($urandom));

    // Asynchronous reset in the middle of a clock.
    #2;
    rst_n = 1'b0;
    mA = resetModel();
    mB = resetModel();
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 400; k++) runCycle(1'b1, 16'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
